// File: rtl/rop_prng_ctrl_pkg.sv
// Shared definitions for the PRNG arbiter: FSM encoding, LFSR width, default seed
// and the LFSR step function used by rop_prng.
package rop_prng_ctrl_pkg;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int LFSR_W = 64;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 64'hFFFF_FFFF_FFFF_FFFF;

  // Fibonacci LFSR, x^64 + x^63 + x^61 + x^60 + 1, shifting towards the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

endpackage

// File: rtl/rop_prng_ctrl_if.sv
// Requester-side bundle of the shared PRNG: request/grant vectors plus the
// delivered random word and the warm-up-complete flag.
interface rop_prng_ctrl_if
  import rop_prng_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [LFSR_W-1:0] rnd_data;
  logic              rnd_ready;

  modport master (
    output req,
    input  gnt,
    input  rnd_data,
    input  rnd_ready
  );

  modport slave (
    input  req,
    output gnt,
    output rnd_data,
    output rnd_ready
  );

endinterface

// File: rtl/rop_prng.sv
// 64-bit LFSR random source; reloads SHF_RNG_RST on reset and steps when rng_en is high.
module rop_prng
  import rop_prng_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SHF_RNG_RST = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rng_en,
  output logic [LFSR_W-1:0] rng_random
);

  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr_q <= SHF_RNG_RST;
    end else if (rng_en) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign rng_random = lfsr_q;

endmodule

// File: rtl/rop_prng_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, cyclic.
module rop_prng_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rop_prng_ctrl.sv
// Shares one rop_prng LFSR among NREQ requesters: warm-up, then one round-robin grant per cycle.
// Define ROP_PRNG_CTRL_IDLE_STEP_EN to keep the LFSR stepping on idle RUN cycles too.
module rop_prng_ctrl
  import rop_prng_ctrl_pkg::*;
#(
  parameter int                NREQ   = 4,
  parameter int                WARMUP = 64,
  parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
  input  logic          clk,
  input  logic          resetn,
  rop_prng_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(WARMUP + 1);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  warm_cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   gnt_p1;
  logic [LFSR_W-1:0] rnd_data_p1;
  logic [LFSR_W-1:0] sample;
  logic              prng_en;
  logic              grant_en;
  logic [NREQ-1:0]   pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rop_prng #(
    .SHF_RNG_RST (SEED)
  ) u_prng (
    .clk        (clk),
    .resetn     (resetn),
    .rng_en     (prng_en),
    .rng_random (sample)
  );

  rop_prng_rr_arb #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nxt = state;
    prng_en   = 1'b0;
    grant_en  = 1'b0;
    case (state)
      WARM: begin
        prng_en = 1'b1;
        if (warm_cnt == CNT_W'(WARMUP - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        grant_en = pick_any;
`ifdef ROP_PRNG_CTRL_IDLE_STEP_EN
        prng_en  = 1'b1;
`else
        prng_en  = pick_any;
`endif
      end
      default: state_nxt = WARM;
    endcase
  end

  // Stage p1: grant and the LFSR word sampled in the request cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= WARM;
      warm_cnt    <= '0;
      rr_ptr      <= '0;
      gnt_p1      <= '0;
      rnd_data_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == WARM && warm_cnt != CNT_W'(WARMUP)) begin
        warm_cnt <= warm_cnt + CNT_W'(1);
      end
      gnt_p1 <= grant_en ? pick_oh : '0;
      if (grant_en) begin
        rnd_data_p1 <= sample;
        rr_ptr      <= (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
      end
    end
  end

  assign bus.gnt       = gnt_p1;
  assign bus.rnd_data  = rnd_data_p1;
  assign bus.rnd_ready = (state == RUN);

endmodule

// File: tb/tb_rop_prng_ctrl.sv
// Directed bench for rop_prng_ctrl: one instance with WARMUP=64, one with WARMUP=1.
module tb_rop_prng_ctrl;
  import rop_prng_ctrl_pkg::*;

  localparam logic [63:0] SEED_C   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] TAP_MASK = 64'hD800_0000_0000_0000;
`ifdef ROP_PRNG_CTRL_IDLE_STEP_EN
  localparam int GAP_STEPS = 6;
`else
  localparam int GAP_STEPS = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn64, rstn1;

  rop_prng_ctrl_if #(.NREQ(4)) bus64 ();
  rop_prng_ctrl_if #(.NREQ(4)) bus1 ();

  rop_prng_ctrl #(.NREQ(4), .WARMUP(64), .SEED(SEED_C)) u_dut64 (
    .clk    (clk),
    .resetn (rstn64),
    .bus    (bus64)
  );

  rop_prng_ctrl #(.NREQ(4), .WARMUP(1), .SEED(SEED_C)) u_dut1 (
    .clk    (clk),
    .resetn (rstn1),
    .bus    (bus1)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden model: advance by n steps, feedback = parity of the tapped bits.
  function automatic logic [63:0] adv(input logic [63:0] s, input int n);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[62:0], ^(v & TAP_MASK)};
    return v;
  endfunction

  initial begin
    logic [3:0]  exp_oh;
    logic [63:0] prev, w1;
    rstn64 = 1'b0;
    rstn1 = 1'b0;
    bus64.req = '0;
    bus1.req = '0;
    tick();
    tick();
    check_val("rst_gnt64", bus64.gnt, 0);
    check_val("rst_data64", bus64.rnd_data, 0);
    check_val("rst_ready64", bus64.rnd_ready, 0);
    check_val("rst_gnt1", bus1.gnt, 0);
    check_val("rst_ready1", bus1.rnd_ready, 0);

    // warm-up of 64 cycles, no requests
    rstn64 = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check_val("t1_ready", bus64.rnd_ready, (i == 64));
      check_val("t1_gnt", bus64.gnt, 0);
    end

    // burst, then mid-burst reset; requests held through the new warm-up
    bus64.req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_oh = 4'b0001 << k;
      check_val("t5_gnt", bus64.gnt, exp_oh);
      check_val("t5_data", bus64.rnd_data, adv(SEED_C, 64 + k));
    end
    rstn64 = 1'b0;
    tick();
    check_val("t5_rst_gnt", bus64.gnt, 0);
    check_val("t5_rst_ready", bus64.rnd_ready, 0);
    check_val("t5_rst_data", bus64.rnd_data, 0);
    rstn64 = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      check_val("t5_warm_gnt", bus64.gnt, 0);
      check_val("t5_warm_ready", bus64.rnd_ready, (i == 64));
    end
    tick();
    check_val("t5_regnt", bus64.gnt, 4'b0001);
    check_val("t5_reseed", bus64.rnd_data, adv(SEED_C, 64));
    bus64.req = '0;

    // WARMUP=1, sole requester held two cycles
    rstn1 = 1'b1;
    tick();
    check_val("t2_ready", bus1.rnd_ready, 1);
    check_val("t2_gnt0", bus1.gnt, 0);
    bus1.req = 4'b0001;
    tick();
    check_val("t2_gnt_a", bus1.gnt, 4'b0001);
    check_val("t2_data_a", bus1.rnd_data, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    check_val("t2_gnt_b", bus1.gnt, 4'b0001);
    check_val("t2_data_b", bus1.rnd_data, 64'hFFFF_FFFF_FFFF_FFFC);
    bus1.req = '0;
    tick();
    check_val("t2_idle_gnt", bus1.gnt, 0);
    check_val("t2_hold", bus1.rnd_data, 64'hFFFF_FFFF_FFFF_FFFC);

    // all four requesting for 8 cycles
    rstn1 = 1'b0;
    tick();
    rstn1 = 1'b1;
    tick();
    bus1.req = 4'b1111;
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_oh = 4'b0001 << (k % 4);
      check_val("t3_gnt", bus1.gnt, exp_oh);
      check_val("t3_data", bus1.rnd_data, adv(SEED_C, 1 + k));
      if (k > 0) check_val("t3_distinct", (bus1.rnd_data != prev), 1);
      prev = bus1.rnd_data;
    end
    bus1.req = '0;

    // requests present during reset and warm-up are not granted early
    bus1.req = 4'b1010;
    rstn1 = 1'b0;
    tick();
    check_val("t4_rst_gnt", bus1.gnt, 0);
    rstn1 = 1'b1;
    tick();
    check_val("t4_ready", bus1.rnd_ready, 1);
    check_val("t4_warm_gnt", bus1.gnt, 0);
    tick();
    check_val("t4_gnt_a", bus1.gnt, 4'b0010);
    check_val("t4_data_a", bus1.rnd_data, adv(SEED_C, 1));
    tick();
    check_val("t4_gnt_b", bus1.gnt, 4'b1000);
    check_val("t4_data_b", bus1.rnd_data, adv(SEED_C, 2));
    bus1.req = '0;

    // two single grants separated by 5 idle cycles
    rstn1 = 1'b0;
    tick();
    rstn1 = 1'b1;
    tick();
    bus1.req = 4'b0001;
    tick();
    check_val("t6_gnt_a", bus1.gnt, 4'b0001);
    w1 = adv(SEED_C, 1);
    check_val("t6_data_a", bus1.rnd_data, w1);
    bus1.req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t6_idle_gnt", bus1.gnt, 0);
      check_val("t6_idle_hold", bus1.rnd_data, w1);
    end
    bus1.req = 4'b0001;
    tick();
    check_val("t6_gnt_b", bus1.gnt, 4'b0001);
    check_val("t6_data_b", bus1.rnd_data, adv(w1, GAP_STEPS));
    bus1.req = '0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
